// File: rtl/seq_datapath.sv
// Self-sequencing datapath: register file, shifter, ALU, A/B/C registers, status and controller FSM.
// Optional build macro SEQ_DP_FASTMOV_EN: MOV reg skips the Rn read (3-cycle accept-to-write).
module seq_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [1:0]       op,
  input  logic [RW-1:0]    rn,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    rm,
  input  logic [1:0]       shift,
  input  logic [7:0]       imm8,
  input  logic [RW-1:0]    dbg_rnum,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic [WIDTH-1:0] datapath_out,
  output logic [2:0]       status,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_t;
  typedef enum logic [2:0] {K_MOVI, K_MOVR, K_ADD, K_CMP, K_AND, K_MVN, K_ILL} kind_t;

  typedef struct packed {
    kind_t         kind;
    logic [RW-1:0] rn;
    logic [RW-1:0] rd;
    logic [RW-1:0] rm;
    logic [1:0]    shift;
    logic [7:0]    imm8;
  } instr_t;

  state_t           state, state_nx;
  kind_t            kind_in;
  instr_t           ir;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a, b;
  logic [WIDTH-1:0] ain, shb, alu, sx;
  logic             accept;
  logic             fz, fn, fv;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign dbg_rdata = regs[dbg_rnum];
  assign sx        = WIDTH'($signed(ir.imm8));

  always_comb begin
    kind_in = K_ILL;
    case ({opcode, op})
      5'b110_10: kind_in = K_MOVI;
      5'b110_00: kind_in = K_MOVR;
      5'b101_00: kind_in = K_ADD;
      5'b101_01: kind_in = K_CMP;
      5'b101_10: kind_in = K_AND;
      5'b101_11: kind_in = K_MVN;
      default:   kind_in = K_ILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) begin
        case (kind_in)
          K_MOVI:  state_nx = WB;
`ifdef SEQ_DP_FASTMOV_EN
          K_MOVR:  state_nx = RDB;
`else
          K_MOVR:  state_nx = RDA;
`endif
          K_ILL:   state_nx = IDLE;
          default: state_nx = RDA;
        endcase
      end
      RDA:     state_nx = RDB;
      RDB:     state_nx = EXEC;
      EXEC:    state_nx = (ir.kind == K_CMP) ? IDLE : WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shifter on the Rm operand, then ALU; MOV reg is ADD with A forced to zero.
  always_comb begin
    shb = b;
    case (ir.shift)
      2'b01:   shb = {b[WIDTH-2:0], 1'b0};
      2'b10:   shb = {1'b0, b[WIDTH-1:1]};
      2'b11:   shb = {b[WIDTH-1], b[WIDTH-1:1]};
      default: shb = b;
    endcase
    ain = (ir.kind == K_MOVR) ? '0 : a;
    case (ir.kind)
      K_CMP:   alu = ain - shb;
      K_AND:   alu = ain & shb;
      K_MVN:   alu = ~shb;
      default: alu = ain + shb;
    endcase
    fz = (alu == '0);
    fn = alu[WIDTH-1];
    fv = (ain[WIDTH-1] ^ shb[WIDTH-1]) & (alu[WIDTH-1] ^ ain[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      ir           <= '{kind: K_ILL, default: '0};
      a            <= '0;
      b            <= '0;
      datapath_out <= '0;
      status       <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (accept) ir <= '{kind: kind_in, rn: rn, rd: rd, rm: rm, shift: shift, imm8: imm8};
      case (state)
        RDA:  a <= regs[ir.rn];
        RDB:  b <= regs[ir.rm];
        EXEC: begin
          datapath_out <= alu;
          if (ir.kind == K_CMP) status <= {fz, fn, fv};
        end
        WB:   regs[ir.rd] <= (ir.kind == K_MOVI) ? sx : datapath_out;
        default: ;
      endcase
      done <= (state == WB) || (state == EXEC && ir.kind == K_CMP);
      err  <= accept && (kind_in == K_ILL);
    end
  end

endmodule
